pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 4: number of pipeline registers after PC (index 0=D, 1=E, 2=M, 3=W); legal range 3..8.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles of a mult/multu; legal range 1..255.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles of a div/divu; legal range 1..255.
REQ-004 Parameter CNT_W, default 32: width of the stall performance counter.
REQ-005 The block SHALL have exactly one clock, clk, and reset is synchronous and active-high, named reset.
REQ-006 Port list:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- stall_data  in  1  D-stage load-use / operand hazard.
- d_uses_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- md_start  in  1  E-stage instruction starts a mult/div this cycle.
- md_is_div  in  1  qualifies md_start: 1=div, 0=mult.
- flush  in  1  exception/interrupt/eret redirect this cycle.
- pc_en  out  1  PC write enable.
- reg_en  out  NUM_REGS  per-register write enable.
- reg_clr  out  NUM_REGS  per-register synchronous clear (bubble insert).
- md_busy  out  1  mult/div unit busy.
- stall_cnt  out  CNT_W  count of stalled cycles.

Function
REQ-007 md_cnt SHALL be an 8-bit state counter; md_busy SHALL equal (md_cnt != 0).
REQ-008 md_start with md_busy=0 SHALL load md_cnt with DIV_CYCLES if md_is_div=1, else MULT_CYCLES, at the next clk edge.
REQ-009 While md_cnt != 0 and no load occurs, md_cnt SHALL decrement by 1 per cycle, stopping at 0 (no wrap).
REQ-010 md_start while md_busy=1 SHALL be ignored (counter unaffected).
REQ-011 flush SHALL NOT alter md_cnt (an in-flight operation completes).
REQ-012 Internal stall = stall_data | (d_uses_md & (md_busy | md_start)); combinational, zero-cycle latency.
REQ-013 Normal (stall=0, flush=0): pc_en=1, reg_en all 1, reg_clr all 0.
REQ-014 Stall (stall=1, flush=0): pc_en=0, reg_en[0]=0, reg_clr[1]=1; all other reg_en=1, all other reg_clr=0.
REQ-015 Flush (flush=1, any stall): pc_en=1, reg_en all 1, reg_clr[0..NUM_REGS-2]=1, reg_clr[NUM_REGS-1]=0; flush has priority over stall.
REQ-016 stall_cnt SHALL increment by 1 on each clk edge where stall=1 and flush=0, saturating at all-ones.
REQ-017 pc_en/reg_en/reg_clr SHALL be purely combinational from inputs and md_cnt; md_busy and stall_cnt are registered state.

Reset
REQ-018 On a clk edge with reset=1: md_cnt=0, stall_cnt=0; reset overrides md_start and stall counting in that cycle.
REQ-019 While reset=1 the outputs SHALL be pc_en=0, reg_en all 1, reg_clr all 1, irrespective of other inputs.
REQ-020 First cycle after reset deassertion with all inputs 0: pc_en=1, reg_en all 1, reg_clr all 0, md_busy=0, stall_cnt=0.
REQ-021 reset asserted during an md operation SHALL abort it (md_busy=0 on the following cycle).

Structure
REQ-022 A shared package SHALL hold the stage index constants (STG_D=0, STG_E=1, STG_M=2, STG_W=3) and the default MULT_CYCLES/DIV_CYCLES values.
REQ-023 The mult/div busy counter SHALL be a sub-module named md_busy_counter (ports clk, reset, start, is_div, busy); the remainder stays in pipe_hazard_ctrl.

Verification
REQ-024 Load-use: stall_data=1 for 1 cycle -> pc_en=0, reg_en=4'b1110, reg_clr=4'b0010 that cycle; stall_cnt 0->1.
REQ-025 Mult then mfhi: md_start=1,md_is_div=0 at cycle 0, d_uses_md=1 from cycle 0 -> stall asserted cycles 0..5, released cycle 6; stall_cnt=6.
REQ-026 Div busy: md_start=1,md_is_div=1, d_uses_md=0 -> md_busy=1 for exactly 10 cycles, no stall; second md_start at cycle 3 ignored.
REQ-027 Flush during stall: stall_data=1 and flush=1 same cycle -> pc_en=1, reg_en=4'b1111, reg_clr=4'b0111, stall_cnt unchanged.
REQ-028 Reset mid-div: reset at cycle 4 of a div -> md_busy=0 next cycle; during reset pc_en=0, reg_clr=4'b1111.
REQ-029 Saturation: CNT_W=4, stall_data held 20 cycles -> stall_cnt reaches 4'hF and holds.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices and mult/div latencies.
package pipe_hazard_ctrl_pkg;

  localparam int STG_D = 0;
  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// Mult/div busy counter: loads the op latency on an accepted start and counts down to idle.
// Latency: busy rises one cycle after start; starts while busy are dropped.
// Backpressure: none; the consumer stalls on busy.
module md_busy_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [7:0] md_cnt_q;
  logic [7:0] md_cnt_d;

  assign busy = (md_cnt_q != 8'd0);

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (start && !busy) begin
      md_cnt_d = is_div ? 8'(DIV_CYCLES) : 8'(MULT_CYCLES);
    end else if (busy) begin
      md_cnt_d = md_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= 8'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: PC/stage enables and bubble clears from stalls, mult/div busy and flush.
// Latency: enables/clears are combinational; md_busy and stall_cnt are registered.
// Backpressure: a stall holds PC and D and bubbles E; flush overrides stall.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 4,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_data,
  input  logic                d_uses_md,
  input  logic                md_start,
  input  logic                md_is_div,
  input  logic                flush,
  output logic                pc_en,
  output logic [NUM_REGS-1:0] reg_en,
  output logic [NUM_REGS-1:0] reg_clr,
  output logic                md_busy,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic             stall;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_is_div),
    .busy   (md_busy)
  );

  // A start in the same cycle must already hold a dependent D-stage op.
  assign stall = stall_data | (d_uses_md & (md_busy | md_start));

  always_comb begin
    pc_en   = 1'b1;
    reg_en  = '1;
    reg_clr = '0;
    if (reset) begin
      pc_en   = 1'b0;
      reg_clr = '1;
    end else if (flush) begin
      reg_clr               = '1;
      reg_clr[NUM_REGS-1]   = 1'b0;
    end else if (stall) begin
      pc_en          = 1'b0;
      reg_en[STG_D]  = 1'b0;
      reg_clr[STG_E] = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
